test_mem_responder: RTL and testbench
=====================================

# test_mem_responder

Behavioural-synthesizable memory responder that sits at the far end of the cache request interface: it accepts 76-bit memory request messages (refills and writebacks issued by a cache or by a bench driver) over a val/rdy handshake. It performs the read or write on an internal word array and returns a 44-bit response message after a programmable latency. It is the standard target for cache-side benches and for the memory port of the coherency top level. At most one request is in flight at a time.

## Interface
- ADDR_W, 10: word-index width; array depth is 2**ADDR_W 32-bit words.
- LATENCY, 2: idle cycles between request accept and response valid (0 allowed, max 15).
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- memreq_msg  in  76  {type[1:0], opaque[7:0], addr[31:0], len[1:0], data[31:0]}.
- memreq_val  in  1  request valid.
- memreq_rdy  out  1  responder can accept.
- memresp_msg  out  44  {type[1:0], opaque[7:0], len[1:0], data[31:0]}.
- memresp_val  out  1  response valid.
- memresp_rdy  in  1  consumer accepts response.

## Operation
- Type codes: 0 = read, 1 = write, 2/3 = reserved (no array access, data 0).
- Word index = addr[ADDR_W+1:2]; higher address bits are ignored (aliasing by modulo). Byte offset = addr[1:0].
- len encoding: 0 = 4 bytes, 1..3 = that many bytes starting at the byte offset. Lanes past byte 3 are dropped, with no wrap into the next word.
- Write: the enabled byte lanes of the addressed word take data bytes 0..n-1, shifted left by 8*offset. The array is updated at the accept edge. Response data is 0.
- Read: the word is read at the accept edge. Response data = word >> (8*offset), masked to len bytes (len 0 gives the full word).
- Response echoes the captured type, opaque and len.
- FSM states:
  - IDLE: memreq_rdy=1. memreq_val & memreq_rdy causes capture and the array op. Next state is WAIT with cnt=LATENCY if LATENCY>0, otherwise RESP.
  - WAIT: cnt decrements each cycle. cnt==1 moves the FSM to RESP.
  - RESP: memresp_val=1 and msg is held stable. memresp_rdy moves the FSM to IDLE.
- memreq_rdy is low in WAIT and RESP. There is no bypass, so a new request is accepted at the earliest one cycle after the response handshake.

## Timing
- Reset values: state IDLE, memreq_rdy=1 after reset deasserts (0 while reset is high), memresp_val=0, memresp_msg=0, cnt=0.
- Array contents are not reset.
- Accept at edge N causes memresp_val to rise after edge N+1+LATENCY. For LATENCY=0, valid is high in the cycle after accept.
- The response is held indefinitely while memresp_rdy=0. The msg must not change while val=1.
- memresp_rdy asserted before val rises has no effect. Handshake occurs on the first edge with val&rdy.
- Reset mid-operation: a pending response is discarded and the FSM returns to IDLE. A write already accepted remains in the array.
- Read-after-write to the same word in back-to-back transactions returns the new data.

## Configuration
- TEST_MEM_RAND_DELAY_EN defined: at each accept, cnt=LATENCY+lfsr[1:0], adding 0–3 extra WAIT cycles. The LFSR advances every cycle and is seeded to 8'h5A on reset. The LATENCY=0 case uses the same formula and enters RESP directly only if the sum is 0.
- Not defined: latency is exactly LATENCY and no LFSR is instantiated.

## Structure
- Shared package mem_msg_pkg: field widths (REQ_W=76, RESP_W=44), field bit positions, type codes MEM_RD/MEM_WR, and the FSM state enum.
- Sub-module lfsr8 (8-bit maximal Fibonacci, taps 8,6,5,4) is instantiated only under TEST_MEM_RAND_DELAY_EN.

## Test plan
- Write type1 opaque 0x00 addr 0x300 len0 data 0x0a0b0c0d, then read opaque 0x01 addr 0x300. Required: read response type0, opaque 0x01, data 0x0a0b0c0d; write response data 0.
- Subword write: addr 0x101 len1 data 0xEE over word 0x11223344. Required: read of addr 0x100 len0 returns 0x1122EE44, and read of addr 0x101 len1 returns 0x000000EE.
- Latency with LATENCY=2 and the macro off: accept at edge N, memresp_val first high after edge N+3. Repeat with LATENCY=0: high after edge N+1.
- Backpressure: hold memresp_rdy=0 for 10 cycles. Required: memresp_val stays 1, msg stays constant, memreq_rdy stays 0, and a second request presented meanwhile is not accepted until the cycle after the response handshake.
- Aliasing: with ADDR_W=10, write 0xDEADBEEF to addr 0x1000, then read addr 0x0000. Required: returns 0xDEADBEEF.
- Reset after accept, during WAIT: memresp_val stays 0 and memreq_rdy=1 one cycle after reset drops. Under the macro, every latency measured over 100 requests is in the range LATENCY..LATENCY+3.

Source files
------------

// File: rtl/mem_msg_pkg.sv
// mem_msg_pkg: shared definitions for the cache-side memory message interface.
//   - REQ_W / RESP_W message widths and the bit position of every field
//   - MEM_RD / MEM_WR type codes (2 and 3 are reserved)
//   - mem_state_e: responder FSM states
//   - lane_mask / word_mask: byte-lane helpers for the len/offset encoding
package mem_msg_pkg;

  localparam int REQ_W  = 76;
  localparam int RESP_W = 44;

  // Request: {type[1:0], opaque[7:0], addr[31:0], len[1:0], data[31:0]}
  localparam int REQ_DATA_LSB = 0;
  localparam int REQ_LEN_LSB  = 32;
  localparam int REQ_ADDR_LSB = 34;
  localparam int REQ_OPQ_LSB  = 66;
  localparam int REQ_TYPE_LSB = 74;

  // Response: {type[1:0], opaque[7:0], len[1:0], data[31:0]}
  localparam int RESP_DATA_LSB = 0;
  localparam int RESP_LEN_LSB  = 32;
  localparam int RESP_OPQ_LSB  = 34;
  localparam int RESP_TYPE_LSB = 42;

  localparam logic [1:0] MEM_RD = 2'd0;
  localparam logic [1:0] MEM_WR = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } mem_state_e;

  // Byte lanes touched by an access of len bytes starting at byte offset off.
  // len 0 means a full word; lanes shifted past byte 3 fall off (no wrap).
  function automatic logic [3:0] lane_mask(input logic [1:0] len, input logic [1:0] off);
    logic [7:0] m;
    m = (len == 2'd0) ? 8'h0F : ((8'h01 << len) - 8'h01);
    m = m << off;
    return m[3:0];
  endfunction

  // Bit mask keeping the low len bytes of a word (len 0 keeps all 32 bits).
  function automatic logic [31:0] word_mask(input logic [1:0] len);
    logic [3:0]  lanes;
    logic [31:0] m;
    lanes = lane_mask(len, 2'd0);
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{lanes[i]}};
    return m;
  endfunction

endpackage

// File: rtl/lfsr8.sv
// lfsr8: 8-bit maximal-length Fibonacci LFSR, taps 8,6,5,4, advancing every
// cycle. Seeded to 8'h5A by synchronous active-high reset.
//   clk   in   clock
//   reset in   synchronous, active-high
//   q     out  current LFSR state
module lfsr8 (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] q
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= 8'h5A;
    else       lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;

endmodule

// File: rtl/test_mem_responder.sv
// test_mem_responder: single-outstanding memory responder for cache benches.
// Accepts a request, performs the read/write on an internal word array at the
// accept edge, and returns the response after a programmable latency.
//   Parameters: ADDR_W (word-index width), LATENCY (0..15 idle cycles)
//   clk, reset            clock; synchronous active-high reset
//   memreq_msg/val/rdy    76-bit request channel (val/rdy handshake)
//   memresp_msg/val/rdy   44-bit response channel (val/rdy handshake)
// Build option: TEST_MEM_RAND_DELAY_EN adds 0..3 pseudo-random extra WAIT
// cycles per request from an lfsr8 instance.
module test_mem_responder
  import mem_msg_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REQ_W-1:0]  memreq_msg,
  input  logic              memreq_val,
  output logic              memreq_rdy,
  output logic [RESP_W-1:0] memresp_msg,
  output logic              memresp_val,
  input  logic              memresp_rdy
);

  // Request field extraction
  logic [1:0]        req_type;
  logic [7:0]        req_opq;
  logic [31:0]       req_addr;
  logic [1:0]        req_len;
  logic [31:0]       req_data;
  logic [ADDR_W-1:0] req_idx;
  logic [1:0]        req_off;

  assign req_type = memreq_msg[REQ_TYPE_LSB +: 2];
  assign req_opq  = memreq_msg[REQ_OPQ_LSB  +: 8];
  assign req_addr = memreq_msg[REQ_ADDR_LSB +: 32];
  assign req_len  = memreq_msg[REQ_LEN_LSB  +: 2];
  assign req_data = memreq_msg[REQ_DATA_LSB +: 32];
  assign req_idx  = req_addr[ADDR_W+1:2];
  assign req_off  = req_addr[1:0];

  // Address bits above the word index alias by design.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  mem_state_e        state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [RESP_W-1:0] msg_q, msg_d;
  logic              val_q, val_d;
  logic [4:0]        cnt_init;
  logic              accept;
  logic [31:0]       rd_word;
  logic [31:0]       rd_data;
  logic [3:0]        wr_lanes;
  logic [31:0]       wr_data;

  logic [31:0] mem [0:(1<<ADDR_W)-1];

`ifdef TEST_MEM_RAND_DELAY_EN
  logic [7:0] lfsr_q;
  logic       unused_lfsr_hi;

  lfsr8 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr_q)
  );

  assign cnt_init       = 5'(LATENCY) + {3'b000, lfsr_q[1:0]};
  assign unused_lfsr_hi = ^lfsr_q[7:2];
`else
  assign cnt_init = 5'(LATENCY);
`endif

  assign memreq_rdy  = (state_q == ST_IDLE) && !reset;
  assign accept      = memreq_val && memreq_rdy;
  assign memresp_msg = msg_q;
  assign memresp_val = val_q;

  assign rd_word  = mem[req_idx];
  assign rd_data  = (rd_word >> {req_off, 3'b000}) & word_mask(req_len);
  assign wr_lanes = lane_mask(req_len, req_off);
  assign wr_data  = req_data << {req_off, 3'b000};

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    msg_d   = msg_q;
    val_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          msg_d[RESP_TYPE_LSB +: 2]  = req_type;
          msg_d[RESP_OPQ_LSB  +: 8]  = req_opq;
          msg_d[RESP_LEN_LSB  +: 2]  = req_len;
          msg_d[RESP_DATA_LSB +: 32] = (req_type == MEM_RD) ? rd_data : 32'h0;
          if (cnt_init == 5'd0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = cnt_init;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) state_d = ST_RESP;
      end
      ST_RESP: begin
        // The valid flop lags entry into RESP by one cycle, so the response
        // appears LATENCY+1 edges after the accept edge.
        if (val_q && memresp_rdy) state_d = ST_IDLE;
        else                      val_d   = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 5'd0;
      msg_q   <= '0;
      val_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      msg_q   <= msg_d;
      val_q   <= val_d;
    end
  end

  // NOTE: the array is deliberately not reset; writes accepted before a
  // reset must survive it, and a reset would rule out RAM inference.
  always_ff @(posedge clk) begin
    if (accept && (req_type == MEM_WR)) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_lanes[i]) mem[req_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_test_mem_responder.sv
// Directed bench for test_mem_responder (default build). Instance 0 uses
// LATENCY=2, instance 1 uses LATENCY=0; both ADDR_W=10.
module tb_test_mem_responder;
  import mem_msg_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [75:0] req_msg  [2];
  logic        req_val  [2];
  logic        req_rdy  [2];
  logic [43:0] resp_msg [2];
  logic        resp_val [2];
  logic        resp_rdy [2];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  test_mem_responder #(.ADDR_W(10), .LATENCY(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .memreq_msg  (req_msg[0]),
    .memreq_val  (req_val[0]),
    .memreq_rdy  (req_rdy[0]),
    .memresp_msg (resp_msg[0]),
    .memresp_val (resp_val[0]),
    .memresp_rdy (resp_rdy[0])
  );

  test_mem_responder #(.ADDR_W(10), .LATENCY(0)) dut0 (
    .clk         (clk),
    .reset       (reset),
    .memreq_msg  (req_msg[1]),
    .memreq_val  (req_val[1]),
    .memreq_rdy  (req_rdy[1]),
    .memresp_msg (resp_msg[1]),
    .memresp_val (resp_val[1]),
    .memresp_rdy (resp_rdy[1])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [43:0] rsp(input logic [1:0] t, input logic [7:0] o,
                                      input logic [1:0] l, input logic [31:0] d);
    return {t, o, l, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on instance s. lat = edges from the accept edge to
  // the first edge after which memresp_val is seen high.
  task automatic do_txn(input int s, input logic [1:0] t, input logic [7:0] o,
                        input logic [31:0] a, input logic [1:0] l, input logic [31:0] d,
                        output logic [43:0] resp, output int lat);
    int budget;
    req_msg[s] = {t, o, a, l, d};
    req_val[s] = 1'b1;
    budget = 0;
    while (!req_rdy[s] && budget < 20) begin
      tick();
      budget++;
    end
    check("req_rdy_timeout", 64'(req_rdy[s]), 64'd1);
    tick();
    req_val[s] = 1'b0;
    lat = 0;
    while (!resp_val[s] && lat < 40) begin
      tick();
      lat++;
    end
    check("resp_val_timeout", 64'(resp_val[s]), 64'd1);
    resp = resp_msg[s];
    resp_rdy[s] = 1'b1;
    tick();
    resp_rdy[s] = 1'b0;
  endtask

  logic [43:0] r;
  logic [43:0] exp_bp;
  int          lat;

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_msg[i]  = '0;
      req_val[i]  = 1'b0;
      resp_rdy[i] = 1'b0;
    end
    tick();
    tick();

    // Reset state
    check("rdy_during_reset", 64'(req_rdy[0]), 64'd0);
    reset = 1'b0;
    #1;
    check("rdy_after_reset", 64'(req_rdy[0]), 64'd1);
    check("val_after_reset", 64'(resp_val[0]), 64'd0);
    check("msg_after_reset", 64'(resp_msg[0]), 64'd0);
    check("rdy0_after_reset", 64'(req_rdy[1]), 64'd1);

    // Full-word write then read, LATENCY=2
    do_txn(0, MEM_WR, 8'h00, 32'h300, 2'd0, 32'h0a0b0c0d, r, lat);
    check("wr_resp", 64'(r), 64'(rsp(MEM_WR, 8'h00, 2'd0, 32'h0)));
    check("wr_latency", 64'(lat), 64'd3);
    do_txn(0, MEM_RD, 8'h01, 32'h300, 2'd0, 32'h0, r, lat);
    check("rd_resp", 64'(r), 64'(rsp(MEM_RD, 8'h01, 2'd0, 32'h0a0b0c0d)));
    check("rd_latency", 64'(lat), 64'd3);

    // Sub-word write into the middle of a word
    do_txn(0, MEM_WR, 8'h02, 32'h100, 2'd0, 32'h11223344, r, lat);
    do_txn(0, MEM_WR, 8'h03, 32'h101, 2'd1, 32'h000000EE, r, lat);
    check("sub_wr_resp", 64'(r), 64'(rsp(MEM_WR, 8'h03, 2'd1, 32'h0)));
    do_txn(0, MEM_RD, 8'h04, 32'h100, 2'd0, 32'h0, r, lat);
    check("sub_rd_word", 64'(r), 64'(rsp(MEM_RD, 8'h04, 2'd0, 32'h1122EE44)));
    do_txn(0, MEM_RD, 8'h05, 32'h101, 2'd1, 32'h0, r, lat);
    check("sub_rd_byte", 64'(r), 64'(rsp(MEM_RD, 8'h05, 2'd1, 32'h000000EE)));

    // LATENCY=0 instance
    do_txn(1, MEM_WR, 8'h10, 32'h040, 2'd0, 32'h87654321, r, lat);
    check("l0_wr_latency", 64'(lat), 64'd1);
    do_txn(1, MEM_RD, 8'h11, 32'h040, 2'd0, 32'h0, r, lat);
    check("l0_rd_latency", 64'(lat), 64'd1);
    check("l0_rd_resp", 64'(r), 64'(rsp(MEM_RD, 8'h11, 2'd0, 32'h87654321)));

    // Backpressure with a second request waiting
    exp_bp = rsp(MEM_RD, 8'h22, 2'd0, 32'h0a0b0c0d);
    req_msg[0] = {MEM_RD, 8'h22, 32'h300, 2'd0, 32'h0};
    req_val[0] = 1'b1;
    tick();
    req_val[0] = 1'b0;
    lat = 0;
    while (!resp_val[0] && lat < 40) begin
      tick();
      lat++;
    end
    check("bp_latency", 64'(lat), 64'd3);
    req_msg[0] = {MEM_RD, 8'h33, 32'h100, 2'd0, 32'h0};
    req_val[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("bp_val_held", 64'(resp_val[0]), 64'd1);
      check("bp_msg_held", 64'(resp_msg[0]), 64'(exp_bp));
      check("bp_req_rdy_low", 64'(req_rdy[0]), 64'd0);
      tick();
    end
    resp_rdy[0] = 1'b1;
    tick();
    resp_rdy[0] = 1'b0;
    check("bp_rdy_after_hs", 64'(req_rdy[0]), 64'd1);
    check("bp_val_after_hs", 64'(resp_val[0]), 64'd0);
    tick();
    req_val[0] = 1'b0;
    check("bp_second_accepted", 64'(req_rdy[0]), 64'd0);
    lat = 0;
    while (!resp_val[0] && lat < 40) begin
      tick();
      lat++;
    end
    check("bp2_latency", 64'(lat), 64'd3);
    check("bp2_resp", 64'(resp_msg[0]), 64'(rsp(MEM_RD, 8'h33, 2'd0, 32'h1122EE44)));
    resp_rdy[0] = 1'b1;
    tick();
    resp_rdy[0] = 1'b0;

    // Address aliasing above the word index
    do_txn(0, MEM_WR, 8'h40, 32'h1000, 2'd0, 32'hDEADBEEF, r, lat);
    do_txn(0, MEM_RD, 8'h41, 32'h0000, 2'd0, 32'h0, r, lat);
    check("alias_rd", 64'(r), 64'(rsp(MEM_RD, 8'h41, 2'd0, 32'hDEADBEEF)));

    // Reserved type: no array access, data 0, fields echoed
    do_txn(0, 2'd2, 8'h50, 32'h300, 2'd2, 32'h55555555, r, lat);
    check("rsvd_resp", 64'(r), 64'(rsp(2'd2, 8'h50, 2'd2, 32'h0)));
    do_txn(0, MEM_RD, 8'h51, 32'h300, 2'd0, 32'h0, r, lat);
    check("rsvd_no_write", 64'(r), 64'(rsp(MEM_RD, 8'h51, 2'd0, 32'h0a0b0c0d)));

    // Lanes past byte 3 are dropped, neighbouring word untouched
    do_txn(0, MEM_WR, 8'h60, 32'h304, 2'd0, 32'h12345678, r, lat);
    do_txn(0, MEM_WR, 8'h61, 32'h303, 2'd3, 32'h00AABBCC, r, lat);
    do_txn(0, MEM_RD, 8'h62, 32'h300, 2'd0, 32'h0, r, lat);
    check("edge_wr_word", 64'(r), 64'(rsp(MEM_RD, 8'h62, 2'd0, 32'hCC0B0C0D)));
    do_txn(0, MEM_RD, 8'h63, 32'h304, 2'd0, 32'h0, r, lat);
    check("edge_no_wrap", 64'(r), 64'(rsp(MEM_RD, 8'h63, 2'd0, 32'h12345678)));
    do_txn(0, MEM_RD, 8'h64, 32'h302, 2'd2, 32'h0, r, lat);
    check("rd_half_off2", 64'(r), 64'(rsp(MEM_RD, 8'h64, 2'd2, 32'h0000CC0B)));

    // Reset during WAIT: response dropped, accepted write kept
    req_msg[0] = {MEM_WR, 8'h70, 32'h200, 2'd0, 32'hCAFEF00D};
    req_val[0] = 1'b1;
    tick();
    req_val[0] = 1'b0;
    reset = 1'b1;
    tick();
    check("rst_mid_rdy_low", 64'(req_rdy[0]), 64'd0);
    reset = 1'b0;
    tick();
    check("rst_mid_rdy", 64'(req_rdy[0]), 64'd1);
    for (int i = 0; i < 4; i++) begin
      check("rst_mid_val", 64'(resp_val[0]), 64'd0);
      tick();
    end
    do_txn(0, MEM_RD, 8'h71, 32'h200, 2'd0, 32'h0, r, lat);
    check("rst_mid_wr_kept", 64'(r), 64'(rsp(MEM_RD, 8'h71, 2'd0, 32'hCAFEF00D)));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
